// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and hex segment table for the display scanner
package seg_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LOAD  = 2'd1,
    SHOW  = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam int SEG_W = 7;

  // Segment patterns {a,b,c,d,e,f,g} for hex digits 0..F, entry 0 leftmost.
  localparam logic [0:15][SEG_W-1:0] SEG_TABLE = {
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to 7-segment decoder
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  // Pure table lookup; the controller registers the result.
  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner; SEG_SCAN_LZ_BLANK_EN adds leading-zero blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    EN,
  input  logic [4*NUM_DIGITS-1:0] DATA,
  input  logic [NUM_DIGITS-1:0]   DP,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   DIG,
  output logic                    frame_start
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                        ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int TW = $clog2(TMAX);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [TW-1:0]           timer, timer_n;
  logic [4*NUM_DIGITS-1:0] frame_data;
  logic [NUM_DIGITS-1:0]   frame_dp;
  logic                    snap;

  logic [3:0]              nib;
  logic [SEG_W-1:0]        dec;
  logic                    suppress;
  logic [SEG_W-1:0]        seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic                    fs_n;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   lz_mask_n;

  // A digit above 0 is blank when it and every digit to its left are zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lz_mask_n = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero     = all_zero & (DATA[4*i +: 4] == 4'h0);
      lz_mask_n[i] = all_zero;
    end
  end

  // Suppression mask is captured alongside the frame snapshot.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      lz_mask <= '0;
    end else if (snap) begin
      lz_mask <= lz_mask_n;
    end
  end

  assign suppress = lz_mask[idx_n];
`else
  assign suppress = 1'b0;
`endif

  // Single shared decoder, fed with the nibble of the digit about to be driven.
  assign nib = frame_data[{idx_n, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (dec)
  );

  // Next state, digit index, timer, and registered-output values.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    if (!EN) begin
      state_n = OFF;
      idx_n   = '0;
      timer_n = '0;
    end else begin
      case (state)
        OFF: begin
          state_n = LOAD;
          idx_n   = '0;
          timer_n = '0;
        end
        LOAD: begin
          state_n = SHOW;
          idx_n   = '0;
          timer_n = '0;
        end
        SHOW: begin
          if (timer == DWELL_LAST) begin
            timer_n = '0;
            if (BLANK_CYCLES == 0) begin
              if (idx == IDX_LAST) begin
                state_n = LOAD;
                idx_n   = '0;
              end else begin
                state_n = SHOW;
                idx_n   = idx + 1'b1;
              end
            end else begin
              state_n = BLANK;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        BLANK: begin
          if (timer == BLANK_LAST) begin
            timer_n = '0;
            if (idx == IDX_LAST) begin
              state_n = LOAD;
              idx_n   = '0;
            end else begin
              state_n = SHOW;
              idx_n   = idx + 1'b1;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          state_n = OFF;
          idx_n   = '0;
          timer_n = '0;
        end
      endcase
    end

    // Snapshot is taken on the edge that enters LOAD, coinciding with frame_start.
    snap  = (state_n == LOAD);
    fs_n  = (state_n == LOAD);
    dig_n = (state_n == SHOW) ? (DIG_ONE << idx_n) : '0;
    dp_n  = (state_n == SHOW) ? frame_dp[idx_n] : 1'b0;
    seg_n = ((state_n == SHOW) && !suppress) ? dec : '0;
  end

  // State, index and timer registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= OFF;
      idx   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      timer <= timer_n;
    end
  end

  // Frame snapshot; held through OFF so only LOAD ever refreshes it.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      frame_data <= '0;
      frame_dp   <= '0;
    end else if (snap) begin
      frame_data <= DATA;
      frame_dp   <= DP;
    end
  end

  // Output registers, updated on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      seg         <= '0;
      dp_out      <= 1'b0;
      DIG         <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_n;
      dp_out      <= dp_n;
      DIG         <= dig_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        EN;
  logic        EN2;
  logic [15:0] DATA;
  logic [3:0]  DP;

  logic [6:0]  seg, seg2;
  logic        dp_out, dp_out2;
  logic [3:0]  DIG, DIG2;
  logic        frame_start, frame_start2;

  int errors = 0;
  int checks = 0;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam logic [6:0] SUP = 7'h00;
`else
  localparam logic [6:0] SUP = 7'h7E;
`endif

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .DATA(DATA), .DP(DP),
    .seg(seg), .dp_out(dp_out), .DIG(DIG), .frame_start(frame_start)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(2), .BLANK_CYCLES(0)) dut2 (
    .CLK(CLK), .CLR(CLR), .EN(EN2), .DATA(DATA), .DP(DP),
    .seg(seg2), .dp_out(dp_out2), .DIG(DIG2), .frame_start(frame_start2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the 16 cycles of one frame after LOAD, then the next LOAD cycle.
  task automatic frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3,
                       input int chg_at, input logic [15:0] chg_data);
    logic [6:0] sv [4];
    logic [3:0] one;
    int d;
    int ph;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    one = 4'b0001;
    for (int p = 0; p < 16; p++) begin
      tick();
      d  = p / 4;
      ph = p % 4;
      if (ph < 3) begin
        check($sformatf("%s dig p%0d", name, p), 16'(DIG), 16'(one << d));
        check($sformatf("%s seg p%0d", name, p), 16'(seg), 16'(sv[d]));
        check($sformatf("%s dp p%0d", name, p), 16'(dp_out), 16'(d == 2));
      end else begin
        check($sformatf("%s gap dig p%0d", name, p), 16'(DIG), 16'h0);
        check($sformatf("%s gap seg p%0d", name, p), 16'(seg), 16'h0);
        check($sformatf("%s gap dp p%0d", name, p), 16'(dp_out), 16'h0);
      end
      check($sformatf("%s fs p%0d", name, p), 16'(frame_start), 16'h0);
      if (p == chg_at) DATA = chg_data;
    end
    tick();
    check({name, " next fs"}, 16'(frame_start), 16'h1);
    check({name, " next dig"}, 16'(DIG), 16'h0);
    check({name, " next seg"}, 16'(seg), 16'h0);
  endtask

  initial begin
    logic [6:0] sv2 [4];
    logic [3:0] one;
    one  = 4'b0001;
    CLR  = 1'b1;
    EN   = 1'b0;
    EN2  = 1'b0;
    DATA = 16'h0000;
    DP   = 4'b0000;
    tick();
    tick();
    check("rst dig", 16'(DIG), 16'h0);
    check("rst seg", 16'(seg), 16'h0);
    check("rst dp", 16'(dp_out), 16'h0);
    check("rst fs", 16'(frame_start), 16'h0);
    check("rst dig2", 16'(DIG2), 16'h0);

    // Basic scan of 12AF with the decimal point on digit 2.
    CLR  = 1'b0;
    EN   = 1'b1;
    DATA = 16'h12AF;
    DP   = 4'b0100;
    tick();
    check("load fs", 16'(frame_start), 16'h1);
    check("load dig", 16'(DIG), 16'h0);
    check("load seg", 16'(seg), 16'h0);
    frame("f1", 7'h47, 7'h77, 7'h6D, 7'h30, -1, 16'h0);

    // Data change during digit 1 must not tear the current frame.
    frame("f2", 7'h47, 7'h77, 7'h6D, 7'h30, 4, 16'h0000);
    frame("f3", 7'h7E, SUP, SUP, SUP, -1, 16'h0);

    // Disable during digit 2, then re-enable restarts at LOAD and digit 0.
    DATA = 16'h12AF;
    for (int p = 0; p < 9; p++) tick();
    check("pre-off dig", 16'(DIG), 16'b0100);
    EN = 1'b0;
    tick();
    check("off dig", 16'(DIG), 16'h0);
    check("off seg", 16'(seg), 16'h0);
    check("off dp", 16'(dp_out), 16'h0);
    tick();
    check("off2 dig", 16'(DIG), 16'h0);
    check("off2 fs", 16'(frame_start), 16'h0);
    EN = 1'b1;
    tick();
    check("reen fs", 16'(frame_start), 16'h1);
    check("reen dig", 16'(DIG), 16'h0);
    tick();
    check("reen dig0", 16'(DIG), 16'b0001);
    check("reen seg0", 16'(seg), 16'h47);

    // Reset pulse during BLANK with EN held high.
    tick();
    tick();
    tick();
    check("blank dig", 16'(DIG), 16'h0);
    CLR = 1'b1;
    tick();
    check("clr dig", 16'(DIG), 16'h0);
    check("clr seg", 16'(seg), 16'h0);
    check("clr fs", 16'(frame_start), 16'h0);
    CLR  = 1'b0;
    DATA = 16'h0050;
    tick();
    check("post-clr fs", 16'(frame_start), 16'h1);
    check("post-clr dig", 16'(DIG), 16'h0);
    frame("f0050", 7'h7E, 7'h5B, SUP, SUP, -1, 16'h0);

    // Zero-blank variant: back-to-back digits, one zero cycle per frame.
    check("dut2 idle dig", 16'(DIG2), 16'h0);
    sv2[0] = 7'h7E; sv2[1] = 7'h5B; sv2[2] = SUP; sv2[3] = SUP;
    EN2 = 1'b1;
    tick();
    check("dut2 load fs", 16'(frame_start2), 16'h1);
    check("dut2 load dig", 16'(DIG2), 16'h0);
    for (int p = 0; p < 8; p++) begin
      tick();
      check($sformatf("dut2 dig p%0d", p), 16'(DIG2), 16'(one << (p / 2)));
      check($sformatf("dut2 seg p%0d", p), 16'(seg2), 16'(sv2[p / 2]));
      check($sformatf("dut2 fs p%0d", p), 16'(frame_start2), 16'h0);
    end
    tick();
    check("dut2 reload fs", 16'(frame_start2), 16'h1);
    check("dut2 reload dig", 16'(DIG2), 16'h0);
    tick();
    check("dut2 wrap dig", 16'(DIG2), 16'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed display scanner that shares one hex-to-7-segment decoder among NUM_DIGITS common-cathode digits.
- Snapshots a packed bank of 4-bit digit values once per frame.
- Drives the digit at each index in turn for a fixed dwell time, with a dead-time gap between digits to prevent ghosting.
- Sits between the counter/register datapath and the board's segment/digit pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DWELL_CYCLES, 50000, CLK cycles each digit is driven (>=1)
BLANK_CYCLES, 500, dead-time CLK cycles between digits (>=0; 0 skips BLANK)

Ports:
CLK  input  1  system clock; all state changes on posedge
CLR  input  1  synchronous active-high reset
EN  input  1  scan enable; 0 forces display off
DATA  input  4*NUM_DIGITS  digit values; digit i = DATA[4i+3:4i], digit 0 is rightmost
DP  input  NUM_DIGITS  decimal point per digit
seg  output  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-high
dp_out  output  1  decimal point of the driven digit, active-high
DIG  output  NUM_DIGITS  one-hot digit enable, active-high
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- CLR=1 at a posedge sets the following, overriding EN:
  - state=OFF, idx=0, timer=0;
  - frame regs=0;
  - seg/dp_out/DIG/frame_start = 0.
- All outputs are registered and change on the same edge as the state.
- State OFF:
  - all outputs 0.
  - EN=1 -> LOAD.
- State LOAD (exactly 1 cycle):
  - latch DATA and DP into frame regs;
  - frame_start=1, idx=0, DIG=0, seg=0;
  - -> SHOW.
- State SHOW:
  - DIG = 1<<idx;
  - seg = decode(frame nibble idx);
  - dp_out = frame DP[idx];
  - timer counts 0..DWELL_CYCLES-1; at terminal count -> BLANK and timer=0.
  - If BLANK_CYCLES=0, go straight to the next-digit decision below instead.
- State BLANK:
  - DIG=0, seg=0, dp_out=0;
  - timer counts 0..BLANK_CYCLES-1;
  - at terminal count: if idx==NUM_DIGITS-1 -> LOAD, else idx+1 and -> SHOW.
- Frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES)+1 cycles.
- Tearing rule: DATA/DP changes are ignored until the next LOAD.
- EN=0 in any non-OFF state:
  - -> OFF on that edge; outputs 0, timer=0, idx=0.
  - The frame regs are retained.
  - Re-enabling always restarts with LOAD.
- Decode (hex) for 0..F: 7E,30,6D,79,33,5B,5F,70,7F,73,77,1F,4E,3D,4F,47 (hex of seg[6:0]).
- timer width = clog2(max(DWELL_CYCLES,BLANK_CYCLES,2)); idx width = clog2(NUM_DIGITS).
- Invariant: DIG has at most one bit set at any time.
- DIG is never high in the same cycle as a transition between different digits; there is always at least 1 gap cycle when BLANK_CYCLES>=1.

Optional Feature:
SEG_SCAN_LZ_BLANK_EN
- Defined: leading-zero suppression.
  - In SHOW, digit idx>0 shows seg=0 (DIG still asserted, dp_out unaffected) if frame nibbles idx..NUM_DIGITS-1 are all zero.
  - Digit 0 is always shown.
  - The suppression mask is computed at LOAD from the snapshot.
- Undefined: every digit is decoded as-is.

Decomposition:
- Package seg_pkg holds:
  - the state enum (OFF, LOAD, SHOW, BLANK);
  - SEG_W=7;
  - the 16-entry hex segment constant table.
- One sub-module, hex7seg: combinational 4-bit in, 7-bit out, using the table.
  - The controller instantiates it once (the shared resource) on the muxed nibble and registers its output.

Test Plan:
1. NUM_DIGITS=4, DWELL=3, BLANK=1; CLR then EN=1, DATA=16'h12AF, DP=4'b0100.
   -> frame_start at cycle 1.
   -> DIG 0001/seg 47 for 3 cycles; 0 for 1 cycle; 0010/seg 77 for 3 cycles; 0100/seg 6D with dp_out=1; 1000/seg 30.
   -> next frame_start 17 cycles after the first.
2. Change DATA to 16'h0000 mid-frame (during digit 1).
   -> digits 1..3 of the current frame keep the old values; seg=7E on all digits only after the next frame_start.
3. Deassert EN during SHOW of digit 2.
   -> next edge DIG=0, seg=0, dp_out=0.
   -> re-assert EN: LOAD then digit 0 (no resume at digit 2).
4. Assert CLR for 1 cycle with EN=1 during BLANK.
   -> all outputs 0; state OFF for that cycle; LOAD on the following edge (EN still 1).
5. BLANK_CYCLES=0, DWELL=2.
   -> DIG sequence 0001,0001,0010,0010,... with no zero gap between digits; only LOAD gives one zero cycle per frame.
6. With SEG_SCAN_LZ_BLANK_EN, DATA=16'h0050.
   -> digits 3 and 2 show seg=0 with DIG asserted; digit 1 seg=5B; digit 0 seg=7E.
   -> without the macro, digits 3 and 2 show 7E.
